// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: frame state encoding, data width, default bit period
package uart_pkg;

    // Frame state; the encoding is shared with the receiver side.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    // 100 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing a tick on the last cycle of each bit
//
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   en    in   count while high; counter cleared while low
//   tick  out  high during the final cycle of each bit period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Wraps to zero on the same edge that ends a bit, so consecutive bits
    // are exactly CLKS_PER_BIT cycles long.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with valid/ready byte input
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   tx_valid  in   byte offered on tx_data
//   tx_data   in   byte to send, sampled on the accept edge only
//   tx_ready  out  transmitter can accept a byte (registered)
//   tx        out  serial line, idles high (registered)
//   busy      out  frame in progress, always !tx_ready (registered)
//   tx_done   out  one-cycle pulse after the stop bit completes (registered)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           bit_idx, bit_idx_next;
    logic                 tx_next, ready_next, done_next;
    logic                 tick;

    // The counter runs only while a frame is in flight; busy is low in IDLE,
    // which also clears it on the accept edge.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx        <= tx_next;
            tx_ready  <= ready_next;
            busy      <= !ready_next;
            tx_done   <= done_next;
        end
    end

    // tx is registered, so each branch computes the line level for the
    // cycle that follows the current edge.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        tx_next      = tx;
        ready_next   = tx_ready;
        done_next    = 1'b0;

        unique case (state)
            IDLE: begin
                tx_next    = 1'b1;
                ready_next = 1'b1;
                if (tx_valid && tx_ready) begin
                    shift_next   = tx_data;
                    bit_idx_next = '0;
                    tx_next      = 1'b0;
                    ready_next   = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == LAST_BIT) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        // Next bit is the one about to land in position 0.
                        bit_idx_next = bit_idx + 1'b1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tx_next    = 1'b1;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at 4 clocks per bit
module tb_uart_tx;

    localparam int N = 4;

    typedef struct {
        logic [7:0] data;
        int         t;
        int         abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         done_seen = 0;
    bit         mon_en = 1'b0;
    bit         lb_en = 1'b0;
    bit         in_frame = 1'b0;
    int         j = 0;
    exp_t       cur;
    exp_t       exp_q[$];
    logic [7:0] rx_q[$];

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, req);
        end
    endtask

    // Offers byte d until accepted; t is the accept edge index (cyc after it).
    task automatic send(input logic [7:0] d, input int abort_rel, output int t);
        int   guard;
        logic r;
        exp_t e;
        guard    = 0;
        t        = -1;
        r        = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (guard < 200) begin
            r = tx_ready;
            @(posedge clk);
            #1;
            guard++;
            if (r === 1'b1) break;
        end
        if (r !== 1'b1) begin
            chk("accept_timeout", 1'b0, guard, 200);
        end else begin
            t = cyc;
            e = '{d, t, (abort_rel < 0) ? -1 : t + abort_rel};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        repeat (2) @(negedge clk);
        while ((exp_q.size() != 0 || in_frame) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) chk("idle_timeout", 1'b0, guard, 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en && tx_done === 1'b1) done_seen++;
    end

    // Frame monitor: each observed start bit pops one expectation and the
    // line is then checked every cycle through the tx_done cycle.
    always @(negedge clk) begin
        logic [9:0] frame;
        logic       exp_b;
        if (mon_en) begin
            if (!in_frame) begin
                if (tx_done !== 1'b0) chk("spurious_done", 1'b0, tx_done, 0);
                if (tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_start", 1'b0, cyc, 0);
                    end else begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        j        = 0;
                        chk("start_time", cyc == cur.t, cyc, cur.t);
                    end
                end
            end
            if (in_frame) begin
                frame = {1'b1, cur.data, 1'b0};
                if (cur.abort >= 0 && cyc >= cur.abort) begin
                    chk("abort_outputs", {tx, tx_ready, busy, tx_done} === 4'b1100,
                        {tx, tx_ready, busy, tx_done}, 4'b1100);
                    in_frame = 1'b0;
                end else if (j < 10 * N) begin
                    exp_b = frame[j / N];
                    chk($sformatf("frame_%02h_bit%0d", cur.data, j / N),
                        {tx, busy, tx_ready, tx_done} === {exp_b, 3'b100},
                        {tx, busy, tx_ready, tx_done}, {exp_b, 3'b100});
                    j++;
                end else begin
                    chk($sformatf("frame_%02h_done", cur.data),
                        {tx, tx_ready, busy, tx_done} === 4'b1101,
                        {tx, tx_ready, busy, tx_done}, 4'b1101);
                    in_frame = 1'b0;
                end
            end
        end
    end

    // Loopback receiver model: mid-bit sampling at the same bit period.
    initial begin : rx_model
        logic [7:0] b;
        logic [7:0] e;
        logic       stop_b;
        forever begin
            @(negedge clk);
            if (lb_en && tx === 1'b0) begin
                repeat (N / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (N) @(negedge clk);
                    b[k] = tx;
                end
                repeat (N) @(negedge clk);
                stop_b = tx;
                if (rx_q.size() == 0) begin
                    chk("rx_unexpected", 1'b0, b, 0);
                end else begin
                    e = rx_q.pop_front();
                    chk("rx_byte", b === e && stop_b === 1'b1, {stop_b, b}, {1'b1, e});
                end
            end
        end
    end

    initial begin : stim
        int         t1;
        int         t2;
        logic [7:0] lb_bytes [3];
        lb_bytes = '{8'h5A, 8'h01, 8'h80};
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {tx, tx_ready, busy, tx_done} === 4'b1100,
            {tx, tx_ready, busy, tx_done}, 4'b1100);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        repeat (200) begin
            @(negedge clk);
            chk("idle_stable", {tx, tx_ready, tx_done} === 3'b110, {tx, tx_ready, tx_done}, 3'b110);
        end

        send(8'hA5, -1, t1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        send(8'h00, -1, t1);
        send(8'hFF, -1, t2);
        chk("b2b_second_accept", t2 == t1 + 10 * N + 1, t2 - t1, 10 * N + 1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        send(8'h96, -1, t1);
        @(negedge clk);
        tx_valid = 1'b0;
        while (cyc < t1 + 9) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        send(8'hC3, 20, t1);
        @(negedge clk);
        tx_valid = 1'b0;
        while (cyc < t1 + 19) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h81, -1, t1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        lb_en = 1'b1;
        foreach (lb_bytes[i]) begin
            rx_q.push_back(lb_bytes[i]);
            send(lb_bytes[i], -1, t1);
            @(negedge clk);
            tx_valid = 1'b0;
            wait_idle();
        end
        lb_en = 1'b0;

        chk("tx_done_count", done_seen == 8, done_seen, 8);
        chk("scoreboard_empty", exp_q.size() == 0 && rx_q.size() == 0,
            exp_q.size() + rx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter, the transmit counterpart of the existing receiver.
- Accepts one byte per valid/ready handshake from the local fabric.
- Serialises each byte as: start bit, 8 data bits LSB first, one stop bit.
- Bit timing comes from an internal baud tick, so a loopback `tx` → receiver `in` link works at matching bit period.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200). Legal range ≥ 2.
- CNT_W, $clog2(CLKS_PER_BIT): baud counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_valid  input  1  byte offered on tx_data.
- tx_data  input  8  byte to send; sampled only on the accept edge.
- tx_ready  output  1  transmitter can accept a byte.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  frame in progress (state ≠ IDLE).
- tx_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (rst_n=0 at an edge): after that edge, all outputs hold these values.
  - tx=1, tx_ready=1, busy=0, tx_done=0.
  - State = IDLE, baud counter = 0, bit index = 0, shift register = 0.
- Reset mid-frame aborts the frame; tx returns high at that edge and no tx_done is issued.
- States: IDLE, START, DATA, STOP.
  - IDLE: tx=1, tx_ready=1.
  - Accept edge T is when tx_valid && tx_ready. At T: latch tx_data into the shift register, clear the baud counter and bit index, go to START.
  - tx_valid with tx_ready=0 is ignored; tx_data changes while busy are ignored.
  - START: tx=0 for cycles T+1 .. T+N (N = CLKS_PER_BIT). On the bit-end edge go to DATA.
  - DATA: bit i is driven on cycles T+1+N(1+i) .. T+N(2+i), for i = 0..7, LSB first.
    - At each bit-end: shift right and increment the bit index.
    - When bit index = 7 at bit-end: go to STOP.
  - STOP: tx=1 for cycles T+1+9N .. T+10N. On the bit-end edge go to IDLE and assert tx_done.
- Post-frame timing:
  - tx_done=1 and tx_ready=1 during cycle T+10N+1.
  - The earliest next accept edge is T+10N+1, giving a back-to-back frame period of 10N+1 cycles.
  - With a continuous tx_valid, tx stays high for exactly 1 cycle between the stop bit and the next start bit.
- Baud counter:
  - Counts 0..N-1 while state ≠ IDLE.
  - Bit-end when counter = N-1; the counter wraps to 0 on the same edge.
  - Held at 0 in IDLE.
- tx, tx_ready, busy and tx_done are all registered; no combinational path from inputs to outputs.
- busy = !tx_ready at all times.
- tx_done is high for exactly one cycle per completed frame.
- Widths: bit index is 3 bits, with no overflow past 7. Counter compare uses CLKS_PER_BIT-1 truncated to CNT_W.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - DATA_BITS = 8;
  - default CLKS_PER_BIT = 868, shared with the receiver side.
- One natural sub-module, uart_baud_tick:
  - Inputs: clk, rst_n, en. Output: tick.
  - Parameter: CLKS_PER_BIT.
  - Behaviour: counter clears while en=0; tick=1 when count = CLKS_PER_BIT-1.
  - Connection: driven with en = busy.

Test Plan (all with CLKS_PER_BIT=4):
- Single byte 0xA5, accept edge T:
  - tx per 4-cycle bit = 0 | 1,0,1,0,0,1,0,1 | 1.
  - tx_done pulses at cycle T+41; tx_ready returns 1 at T+41.
- Back-to-back 0x00 then 0xFF with tx_valid held high:
  - Second accept at T+41; exactly 1 idle-high cycle between frames.
  - Second frame bits are 0 | 1×8 | 1.
- Handshake hold-off: pulse tx_valid with 0x3C at T+10 while busy.
  - Ignored; the frame still carries the original byte; exactly one tx_done.
- Reset mid-frame: assert rst_n=0 at cycle T+20 (inside DATA).
  - tx=1, tx_ready=1, busy=0 after that edge; no tx_done.
  - A new byte 0x81 sent after release transmits 0 | 1,0,0,0,0,0,0,1 | 1.
- Loopback: tx wired to the receiver `in` (same bit period), send 0x5A, 0x01, 0x80.
  - Receiver data_out matches each byte in order; rx_ready asserts after each frame.
- Idle stability: tx_valid=0 for 200 cycles after reset.
  - tx constantly 1, tx_ready constantly 1, tx_done never asserted.
